pipeline_regfile: RTL and testbench

PIPELINE_REGFILE -- requirements
Module: pipeline_regfile

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 59 +++++
 rtl/pipeline_regfile.sv | 84 ++++++++
 tb/tb_pipeline_regfile.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared widths and types for the pipeline register file slice.
package pipeline_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int PEND_CNT_W = 6;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic logic is_x0(input reg_addr_t addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: set on late-result issue, clear on write-back,
// bulk clear on flush, plus a registered population count.
module rf_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NR = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  reg_addr_t             issue_rd,
    input  logic                  issue_pend,
    input  logic                  reg_write_WB,
    input  reg_addr_t             rd_WB,
    input  logic                  flush,
    output logic [NR-1:0]         pending,
    output logic [PEND_CNT_W-1:0] pend_count
);

    logic [NR-1:0]         set_vec;
    logic [NR-1:0]         clr_vec;
    logic [NR-1:0]         pending_nxt;
    logic [PEND_CNT_W-1:0] count_nxt;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_pend && !is_x0(issue_rd))
            set_vec[issue_rd] = 1'b1;
        if (reg_write_WB)
            clr_vec[rd_WB] = 1'b1;
    end

    // Set is applied after clear so the newer producer keeps the mark.
    always_comb begin
        if (flush)
            pending_nxt = '0;
        else
            pending_nxt = (pending & ~clr_vec) | set_vec;
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 1; i < NR; i++)
            count_nxt = count_nxt + PEND_CNT_W'(pending_nxt[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            pending    <= pending_nxt;
            pend_count <= count_nxt;
        end
    end

endmodule

// File: rtl/pipeline_regfile.sv
// Two-read/one-write register file with load-use scoreboard and hazard stall.
// Optional write-back bypass on reads is enabled by defining RF_WB_BYPASS_EN.
module pipeline_regfile
    import pipeline_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  reg_addr_t             rs1_addr,
    input  reg_addr_t             rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  reg_addr_t             rd_WB,
    input  logic [XLEN-1:0]       write_data_WB,
    input  logic                  reg_write_WB,
    input  logic                  issue_valid,
    input  reg_addr_t             issue_rd,
    input  logic                  issue_pend,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic [PEND_CNT_W-1:0] pend_count
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                bypass1;
    logic                bypass2;
    logic                haz1;
    logic                haz2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (reg_write_WB && !is_x0(rd_WB)) begin
            regs[rd_WB] <= write_data_WB;
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign bypass1 = reg_write_WB && !is_x0(rd_WB) && (rd_WB == rs1_addr);
    assign bypass2 = reg_write_WB && !is_x0(rd_WB) && (rd_WB == rs2_addr);
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    // Outputs are forced to zero during reset so a live write-back cannot leak through the bypass.
    always_comb begin
        rs1_data = '0;
        if (!reset && !is_x0(rs1_addr))
            rs1_data = bypass1 ? write_data_WB : regs[rs1_addr];
    end

    always_comb begin
        rs2_data = '0;
        if (!reset && !is_x0(rs2_addr))
            rs2_data = bypass2 ? write_data_WB : regs[rs2_addr];
    end

    rf_scoreboard #(
        .NR (NUM_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_pend   (issue_pend),
        .reg_write_WB (reg_write_WB),
        .rd_WB        (rd_WB),
        .flush        (flush),
        .pending      (pending),
        .pend_count   (pend_count)
    );

    assign haz1 = rs1_used && pending[rs1_addr] && !bypass1;
    assign haz2 = rs2_used && pending[rs2_addr] && !bypass2;
    assign hazard_stall = !reset && (haz1 || haz2);

endmodule

// File: tb/tb_pipeline_regfile.sv
// Directed self-checking bench for pipeline_regfile; expectations follow RF_WB_BYPASS_EN.
module tb_pipeline_regfile;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    reg_addr_t   rs1_addr, rs2_addr, rd_WB, issue_rd;
    logic        rs1_used, rs2_used, reg_write_WB, issue_valid, issue_pend, flush;
    logic [63:0] write_data_WB, rs1_data, rs2_data;
    logic        hazard_stall;
    logic [5:0]  pend_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_regfile #(.XLEN(64), .NUM_REGS(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .rd_WB         (rd_WB),
        .write_data_WB (write_data_WB),
        .reg_write_WB  (reg_write_WB),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_pend    (issue_pend),
        .flush         (flush),
        .hazard_stall  (hazard_stall),
        .pend_count    (pend_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        rd_WB = '0; write_data_WB = '0; reg_write_WB = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_pend = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #2;
        total++; if (rs1_data !== 64'h0) begin bad++; $display("FAIL reset_rs1 got=%h exp=0", rs1_data); end
        total++; if (rs2_data !== 64'h0) begin bad++; $display("FAIL reset_rs2 got=%h exp=0", rs2_data); end
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", hazard_stall); end
        total++; if (pend_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pend_count); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        rd_WB = 5'd5; write_data_WB = 64'h1234; reg_write_WB = 1'b1;
        tick();
        clear_inputs();
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        total++; if (rs1_data !== 64'h1234) begin bad++; $display("FAIL wr_x5_rs1 got=%h exp=1234", rs1_data); end
        total++; if (rs2_data !== 64'h1234) begin bad++; $display("FAIL wr_x5_rs2 got=%h exp=1234", rs2_data); end
        rd_WB = 5'd0; write_data_WB = 64'hFFFF; reg_write_WB = 1'b1;
        rs1_addr = 5'd0;
        #1;
        total++; if (rs1_data !== 64'h0) begin bad++; $display("FAIL x0_during_write got=%h exp=0", rs1_data); end
        tick();
        clear_inputs();
        #1;
        total++; if (rs1_data !== 64'h0) begin bad++; $display("FAIL x0_after_write got=%h exp=0", rs1_data); end
    endtask

    task automatic test_hazard();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_pend = 1'b1;
        tick();
        clear_inputs();
        rs2_addr = 5'd7; rs2_used = 1'b1;
        #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL haz_pending got=%b exp=1", hazard_stall); end
        total++; if (pend_count !== 6'd1) begin bad++; $display("FAIL haz_count got=%0d exp=1", pend_count); end
        rs2_used = 1'b0;
        #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL haz_unused got=%b exp=0", hazard_stall); end
        rs2_used = 1'b1;
        rd_WB = 5'd7; write_data_WB = 64'hAB; reg_write_WB = 1'b1;
        #1;
`ifdef RF_WB_BYPASS_EN
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL haz_wb_stall got=%b exp=0", hazard_stall); end
        total++; if (rs2_data !== 64'hAB) begin bad++; $display("FAIL haz_wb_data got=%h exp=ab", rs2_data); end
`else
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL haz_wb_stall got=%b exp=1", hazard_stall); end
        total++; if (rs2_data !== 64'h0) begin bad++; $display("FAIL haz_wb_data got=%h exp=0", rs2_data); end
`endif
        tick();
        reg_write_WB = 1'b0; rd_WB = '0; write_data_WB = '0;
        #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL haz_after_stall got=%b exp=0", hazard_stall); end
        total++; if (rs2_data !== 64'hAB) begin bad++; $display("FAIL haz_after_data got=%h exp=ab", rs2_data); end
        total++; if (pend_count !== 6'd0) begin bad++; $display("FAIL haz_after_count got=%0d exp=0", pend_count); end
        clear_inputs();
    endtask

    task automatic test_set_wins();
        issue_valid = 1'b1; issue_rd = 5'd9; issue_pend = 1'b1;
        tick();
        total++; if (pend_count !== 6'd1) begin bad++; $display("FAIL setwin_pre got=%0d exp=1", pend_count); end
        rd_WB = 5'd9; write_data_WB = 64'h99; reg_write_WB = 1'b1;
        tick();
        clear_inputs();
        rs1_addr = 5'd9; rs1_used = 1'b1;
        #1;
        total++; if (pend_count !== 6'd1) begin bad++; $display("FAIL setwin_count got=%0d exp=1", pend_count); end
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL setwin_stall got=%b exp=1", hazard_stall); end
        total++; if (rs1_data !== 64'h99) begin bad++; $display("FAIL setwin_data got=%h exp=99", rs1_data); end
        rs1_used = 1'b0;
        rd_WB = 5'd9; write_data_WB = 64'h9A; reg_write_WB = 1'b1;
        tick();
        clear_inputs();
        total++; if (pend_count !== 6'd0) begin bad++; $display("FAIL setwin_clear got=%0d exp=0", pend_count); end
    endtask

    task automatic test_flush();
        issue_valid = 1'b1; issue_pend = 1'b1;
        issue_rd = 5'd3; tick();
        issue_rd = 5'd4; tick();
        issue_rd = 5'd10; tick();
        clear_inputs();
        rs1_addr = 5'd3; rs1_used = 1'b1;
        #1;
        total++; if (pend_count !== 6'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", pend_count); end
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL flush_pre_stall got=%b exp=1", hazard_stall); end
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd11; issue_pend = 1'b1;
        tick();
        flush = 1'b0; issue_valid = 1'b0; issue_pend = 1'b0;
        rs2_addr = 5'd11; rs2_used = 1'b1;
        #1;
        total++; if (pend_count !== 6'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", pend_count); end
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", hazard_stall); end
        clear_inputs();
    endtask

    task automatic test_reset_midcycle();
        for (int i = 1; i < 32; i++) begin
            rd_WB = reg_addr_t'(i); write_data_WB = 64'h1000 + 64'(i); reg_write_WB = 1'b1;
            issue_valid = 1'b1; issue_rd = reg_addr_t'(i); issue_pend = 1'b1;
            tick();
        end
        clear_inputs();
        rs1_addr = 5'd17; rs2_addr = 5'd31;
        #1;
        total++; if (pend_count !== 6'd31) begin bad++; $display("FAIL full_count got=%0d exp=31", pend_count); end
        total++; if (rs1_data !== 64'h1011) begin bad++; $display("FAIL full_x17 got=%h exp=1011", rs1_data); end
        total++; if (rs2_data !== 64'h101F) begin bad++; $display("FAIL full_x31 got=%h exp=101f", rs2_data); end
        issue_valid = 1'b1; issue_rd = 5'd31; issue_pend = 1'b1;
        tick();
        issue_valid = 1'b0; issue_pend = 1'b0;
        total++; if (pend_count !== 6'd31) begin bad++; $display("FAIL full_nowrap got=%0d exp=31", pend_count); end
        rs1_used = 1'b1; rs2_used = 1'b1;
        rd_WB = 5'd5; write_data_WB = 64'hDEAD; reg_write_WB = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd6; issue_pend = 1'b1;
        rs1_addr = 5'd5;
        #2;
        reset = 1'b1;
        #1;
        total++; if (rs1_data !== 64'h0) begin bad++; $display("FAIL rst_mid_rs1 got=%h exp=0", rs1_data); end
        total++; if (rs2_data !== 64'h0) begin bad++; $display("FAIL rst_mid_rs2 got=%h exp=0", rs2_data); end
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", hazard_stall); end
        total++; if (pend_count !== 6'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", pend_count); end
        tick();
        clear_inputs();
        reset = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd6; rs2_used = 1'b1;
        #1;
        total++; if (rs1_data !== 64'h0) begin bad++; $display("FAIL rst_ignored_wr got=%h exp=0", rs1_data); end
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL rst_ignored_issue got=%b exp=0", hazard_stall); end
        total++; if (pend_count !== 6'd0) begin bad++; $display("FAIL rst_after_count got=%0d exp=0", pend_count); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hazard();
        test_set_wins();
        test_flush();
        test_reset_midcycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
